// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for three masters in front of a two-slave write interconnect.
// It issues one packet at a time to the selected slave, with a timeout abort.
module rr_bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_valid,
  input  logic [6:0] req_data_1,
  input  logic [6:0] req_data_2,
  input  logic [6:0] req_data_3,
  input  logic       ready_slave1,
  input  logic       ready_slave2,
  output logic [2:0] req_ready,
  output logic       valid_slave1,
  output logic       valid_slave2,
  output logic [2:0] addr_out,
  output logic [2:0] value_out,
  output logic [2:0] done,
  output logic [2:0] err,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_last;
  logic [2:0]       r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_req_ready;
  logic             r_valid1;
  logic             r_valid2;
  logic [2:0]       r_addr;
  logic [2:0]       r_value;
  logic [2:0]       r_done;
  logic [2:0]       r_err;
  logic             r_busy;

  logic [2:0] w_gnt_oh;
  logic [1:0] w_gnt;
  logic [6:0] w_pkt;
  logic       w_hs;

  // Search starts just after the last granted master and ends on it.
  always_comb begin
    w_gnt_oh = 3'b000;
    unique case (r_last)
      2'd1: begin
        if      (req_valid[1]) w_gnt_oh = 3'b010;
        else if (req_valid[2]) w_gnt_oh = 3'b100;
        else if (req_valid[0]) w_gnt_oh = 3'b001;
      end
      2'd2: begin
        if      (req_valid[2]) w_gnt_oh = 3'b100;
        else if (req_valid[0]) w_gnt_oh = 3'b001;
        else if (req_valid[1]) w_gnt_oh = 3'b010;
      end
      default: begin
        if      (req_valid[0]) w_gnt_oh = 3'b001;
        else if (req_valid[1]) w_gnt_oh = 3'b010;
        else if (req_valid[2]) w_gnt_oh = 3'b100;
      end
    endcase
  end

  always_comb begin
    w_gnt = 2'd3;
    w_pkt = req_data_3;
    if (w_gnt_oh[0]) begin
      w_gnt = 2'd1;
      w_pkt = req_data_1;
    end else if (w_gnt_oh[1]) begin
      w_gnt = 2'd2;
      w_pkt = req_data_2;
    end
  end

  assign w_hs = (r_valid1 & ready_slave1) | (r_valid2 & ready_slave2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd3;
      r_owner     <= 3'b000;
      r_cnt       <= '0;
      r_req_ready <= 3'b000;
      r_valid1    <= 1'b0;
      r_valid2    <= 1'b0;
      r_addr      <= 3'd0;
      r_value     <= 3'd0;
      r_done      <= 3'b000;
      r_err       <= 3'b000;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= 3'b000;
      r_done      <= 3'b000;
      r_err       <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_state     <= S_ISSUE;
            r_last      <= w_gnt;
            r_owner     <= w_gnt_oh;
            r_req_ready <= w_gnt_oh;
            r_addr      <= w_pkt[5:3];
            r_value     <= w_pkt[2:0];
            r_valid1    <= ~w_pkt[6];
            r_valid2    <= w_pkt[6];
            r_busy      <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_ISSUE: begin
          // Handshake is tested first so it wins over a coincident timeout.
          if (w_hs) begin
            r_state  <= S_IDLE;
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= r_owner;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state  <= S_IDLE;
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= r_owner;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign valid_slave1 = r_valid1;
  assign valid_slave2 = r_valid2;
  assign addr_out     = r_addr;
  assign value_out    = r_value;
  assign done         = r_done;
  assign err          = r_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed and random transactions checked against
// a transaction-level round-robin / timeout model.
module tb_rr_bus_arbiter;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic [2:0] req_valid;
  logic [6:0] req_data_1, req_data_2, req_data_3;
  logic       ready_slave1, ready_slave2;
  logic [2:0] req_ready;
  logic       valid_slave1, valid_slave2;
  logic [2:0] addr_out, value_out, done, err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests, their packets and the last granted master.
  logic [2:0] pend;
  logic [6:0] pkt [3];
  int         last;

  rr_bus_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data_1(req_data_1), .req_data_2(req_data_2), .req_data_3(req_data_3),
    .ready_slave1(ready_slave1), .ready_slave2(ready_slave2),
    .req_ready(req_ready), .valid_slave1(valid_slave1), .valid_slave2(valid_slave2),
    .addr_out(addr_out), .value_out(value_out), .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  8'(req_ready), 8'h0);
    chk({tag, "_v1"},   8'(valid_slave1), 8'h0);
    chk({tag, "_v2"},   8'(valid_slave2), 8'h0);
    chk({tag, "_addr"}, 8'(addr_out), 8'h0);
    chk({tag, "_val"},  8'(value_out), 8'h0);
    chk({tag, "_done"}, 8'(done), 8'h0);
    chk({tag, "_err"},  8'(err), 8'h0);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
  endtask

  task automatic drive_reqs();
    req_valid  = pend;
    req_data_1 = pkt[0];
    req_data_2 = pkt[1];
    req_data_3 = pkt[2];
  endtask

  task automatic set_ready(input logic sel, input logic r);
    if (sel) begin
      ready_slave2 = r;
      ready_slave1 = 1'($urandom);
    end else begin
      ready_slave1 = r;
      ready_slave2 = 1'($urandom);
    end
  endtask

  task automatic add_req(input int m, input logic [6:0] p);
    pend[m-1] = 1'b1;
    pkt[m-1]  = p;
  endtask

  // One full transaction; delay = cycles the target slave keeps ready low.
  task automatic do_txn(input int delay);
    int         m;
    int         n;
    logic       sel;
    logic       hs;
    logic [2:0] oh;
    logic [6:0] p;
    m = 0;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = ((last - 1 + k) % 3) + 1;
      if (m == 0 && pend[c-1]) m = c;
    end
    p   = pkt[m-1];
    sel = p[6];
    oh  = 3'b001 << (m - 1);
    hs  = (delay <= TO - 1);
    n   = hs ? delay + 1 : TO;
    drive_reqs();
    @(posedge clk); #1;
    $display("txn: master %0d pkt %b delay %0d -> expect %s after %0d valid cycles",
             m, p, delay, hs ? "done" : "err", n);
    chk("grant_rdy",  8'(req_ready), 8'(oh));
    chk("grant_busy", 8'(busy), 8'h1);
    chk("grant_v1",   8'(valid_slave1), 8'(!sel));
    chk("grant_v2",   8'(valid_slave2), 8'(sel));
    chk("grant_addr", 8'(addr_out), 8'(p[5:3]));
    chk("grant_val",  8'(value_out), 8'(p[2:0]));
    chk("grant_done", 8'(done), 8'h0);
    chk("grant_err",  8'(err), 8'h0);
    last = m;
    pend[m-1] = 1'b0;
    drive_reqs();
    set_ready(sel, delay == 0);
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      chk("hold_v1",   8'(valid_slave1), 8'(!sel));
      chk("hold_v2",   8'(valid_slave2), 8'(sel));
      chk("hold_rdy",  8'(req_ready), 8'h0);
      chk("hold_done", 8'(done), 8'h0);
      chk("hold_err",  8'(err), 8'h0);
      set_ready(sel, c >= delay);
    end
    @(posedge clk); #1;
    chk("end_v1",   8'(valid_slave1), 8'h0);
    chk("end_v2",   8'(valid_slave2), 8'h0);
    chk("end_busy", 8'(busy), 8'h0);
    chk("end_done", 8'(done), hs ? 8'(oh) : 8'h0);
    chk("end_err",  8'(err), hs ? 8'h0 : 8'(oh));
    chk("end_addr", 8'(addr_out), 8'(p[5:3]));
    chk("end_val",  8'(value_out), 8'(p[2:0]));
    ready_slave1 = 1'b0;
    ready_slave2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pend  = 3'b000;
    for (int i = 0; i < 3; i++) pkt[i] = 7'd0;
    last  = 3;
    ready_slave1 = 1'b0;
    ready_slave2 = 1'b0;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Single request to slave 1, always ready.
    add_req(1, 7'b0_101_011);
    do_txn(0);

    // Slave 2 stalls for 4 cycles.
    add_req(2, {1'b1, 6'($urandom)});
    do_txn(4);

    // Slave never ready: timeout, then a normal transaction.
    add_req(3, {1'b0, 6'($urandom)});
    do_txn(100);
    add_req(1, 7'($urandom));
    do_txn(0);

    // Handshake coincides with the final count value.
    add_req(2, {1'b0, 6'($urandom)});
    do_txn(TO - 1);
    add_req(3, {1'b1, 6'($urandom)});
    do_txn(TO - 1);

    // All masters requesting continuously, granted master re-requests at once.
    for (int i = 1; i <= 3; i++) add_req(i, 7'($urandom));
    for (int i = 0; i < 9; i++) begin
      do_txn(0);
      add_req(last, 7'($urandom));
    end
    pend = 3'b000;
    drive_reqs();
    @(posedge clk); #1;
    chk("drain_busy", 8'(busy), 8'h0);
    chk("drain_done", 8'(done), 8'h0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      for (int m = 1; m <= 3; m++)
        if (!pend[m-1] && ($urandom_range(0, 2) == 0)) add_req(m, 7'($urandom));
      if (pend == 3'b000) begin
        drive_reqs();
        @(posedge clk); #1;
        $display("idle cycle");
        chk("idle_busy", 8'(busy), 8'h0);
        chk("idle_v",    8'({valid_slave1, valid_slave2}), 8'h0);
        chk("idle_rdy",  8'(req_ready), 8'h0);
      end else begin
        case ($urandom_range(0, 5))
          0, 1:    do_txn(0);
          2:       do_txn($urandom_range(1, 5));
          3:       do_txn(TO - 1);
          4:       do_txn(TO);
          default: do_txn(TO + 5);
        endcase
      end
    end

    // Reset in the middle of ISSUE.
    add_req(2, {1'b0, 6'($urandom)});
    add_req(3, {1'b1, 6'($urandom)});
    drive_reqs();
    @(posedge clk); #1;
    chk("pre_rst_busy", 8'(busy), 8'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(posedge clk); #1;
    chk_all_zero("mid_rst_hold");
    last = 3;
    for (int i = 1; i <= 3; i++) add_req(i, 7'($urandom));
    @(negedge clk) rst_n = 1'b1;
    $display("reset released with all masters requesting");
    do_txn(0);
    chk("post_rst_first", 8'(last), 8'd1);
    do_txn(0);
    do_txn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin request arbiter and transaction sequencer that sits between three bus masters and the two-slave write interconnect. It accepts one 7-bit packet at a time from three requesters under a valid/ready handshake, routes it to slave 1 or slave 2, and reports completion to the originating master. If a slave does not respond within `TIMEOUT` cycles, the arbiter aborts the transaction and reports an error.

## Interface
- `TIMEOUT`, 15, number of cycles `valid_slaveX` stays high without a slave handshake before abort; legal range 2..2^`CNT_W`-1
- `CNT_W`, 4, width of the timeout counter
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  3  bit m-1 = master m request pending; held high until `req_ready[m-1]` is seen
- `req_data_1`, `req_data_2`, `req_data_3`  in  7 each  packet {slave_sel[6], addr[5:3], data[2:0]}; slave_sel 0 = slave 1, 1 = slave 2
- `ready_slave1`, `ready_slave2`  in  1 each  slave ready
- `req_ready`  out  3  one-cycle accept pulse to the granted master
- `valid_slave1`, `valid_slave2`  out  1 each  transfer valid toward the selected slave
- `addr_out`, `value_out`  out  3 each  latched addr and data of the current transaction
- `done`  out  3  one-cycle completion pulse, per master
- `err`  out  3  one-cycle timeout pulse, per master
- `busy`  out  1  high while state is ISSUE

## Operation
- FSM with two states:
  - IDLE: at a clock edge with any `req_valid` bit set, grant exactly one master, latch its packet, clear the counter, and go to ISSUE. With no `req_valid` bit set, stay in IDLE.
  - ISSUE: drive `valid_slaveX`. On an edge where `valid_slaveX` and `ready_slaveX` are both high, go to IDLE and pulse `done`. On an edge where the count equals `TIMEOUT`-1 without a handshake, go to IDLE and pulse `err`.
- Round-robin arbitration:
  - Pointer `last` (1..3) holds the last granted master.
  - Search order is `last`+1, `last`+2, `last`, wrapping modulo 3.
  - The pointer updates only on a grant. Reset value is 3, so master 1 has first priority.
- Slave routing: bit 6 of the latched packet selects the slave. `valid_slave1` and `valid_slave2` are never high in the same cycle.
- `addr_out` and `value_out` come from the latched packet. They hold their value through ISSUE and the following IDLE, and change only on the next grant.
- Timeout counter: `CNT_W` bits wide, increments on every ISSUE edge without a handshake.
- Simultaneous handshake and timeout on the same edge: the handshake wins. `done` pulses, `err` does not.
- A master must deassert `req_valid` (or present a new packet) on the edge after it sees `req_ready`. If its `req_valid` is still high in IDLE, it counts as a new request.
- `req_data_m` is sampled only on the grant edge.
- Reset mid-transaction drops the transaction with no `done` or `err`. State returns to IDLE and `last` returns to 3.

## Timing
- Reset values: all outputs 0, state IDLE, `last` = 3.
- All outputs are registered.
- Grant edge E1: in the cycle after E1, `req_ready[m-1]`, `busy`, `valid_slaveX`, `addr_out` and `value_out` are all valid.
- Handshake edge Eh: in the cycle after Eh, `valid_slaveX` = 0, `busy` = 0 and `done[m-1]` = 1, each for one cycle.
- Minimum transaction, slave always ready: grant at E1, handshake at E2, `done` in the cycle after E2, next grant possible at E3. Throughput is therefore 1 transaction per 2 cycles.
- Timeout: `valid_slaveX` stays high for exactly `TIMEOUT` cycles. `err` pulses in the cycle `valid_slaveX` falls.

## Test plan
- Single request, slave 1 ready: `req_data_1`=7'b0_101_011, `req_valid`=001 → `req_ready`=001 after E1; `valid_slave1`=1, `addr_out`=5, `value_out`=3; `done`=001 after E2; `valid_slave2` stays 0.
- All three request continuously, both slaves ready: grants come in order 1,2,3,1,2,3, one every 2 cycles; each `done` bit pulses once per 6 cycles.
- Slave 2 holds `ready_slave2` low for 4 cycles with `TIMEOUT`=15, packet bit6=1: `valid_slave2` high for 5 cycles, then `done` pulses; `err` stays 000.
- Slave never ready, `TIMEOUT`=15: `valid_slave1` high for exactly 15 cycles, then `err`=one-hot for the granted master for one cycle; `done`=000; the next request is granted normally.
- Handshake on the same edge as the count reaching 14: `done` pulses, `err` stays 000.
- `rst_n` pulsed low during ISSUE: all outputs drop to 0 at once with no `done` or `err`; after release, requests on all masters grant master 1 first.
